// File: rtl/psu_cntseq_prog_pkg.sv
// Shared CNT entry layout, control-word/timing codes, program indices and
// the default INIT/MEAS/RESM sequences used by loaders and benches.
package psu_cntseq_prog_pkg;

    localparam int unsigned CNT_TIME_BW  = 8;
    localparam int unsigned CNT_CWD_BW   = 5;
    localparam int unsigned CNT_ENT_BW   = CNT_TIME_BW + 2 * CNT_CWD_BW;
    localparam int unsigned CNT_NUM_PROG = 4;
    localparam int unsigned CNT_MAX_LEN  = 32;
    localparam int unsigned CNT_REP_BW   = 8;

    localparam logic [CNT_CWD_BW-1:0] CWD_IDLE = 5'h00;
    localparam logic [CNT_CWD_BW-1:0] CWD_I    = 5'h01;
    localparam logic [CNT_CWD_BW-1:0] CWD_MEAS = 5'h02;
    localparam logic [CNT_CWD_BW-1:0] CWD_RESM = 5'h04;
    localparam logic [CNT_CWD_BW-1:0] CWD_INIT = 5'h08;
    localparam logic [CNT_CWD_BW-1:0] CWD_HOLD = 5'h10;

    localparam logic [CNT_TIME_BW-1:0] INIT_CYCLE = 8'd16;
    localparam logic [CNT_TIME_BW-1:0] MEAS_CYCLE = 8'd40;
    localparam logic [CNT_TIME_BW-1:0] RESM_CYCLE = 8'd8;

    localparam int unsigned SELCNT_INIT = 0;
    localparam int unsigned SELCNT_MEAS = 1;
    localparam int unsigned SELCNT_RESM = 2;

    localparam int unsigned INIT_LEN = 3;
    localparam int unsigned MEAS_LEN = 2;
    localparam int unsigned RESM_LEN = 20;

    typedef enum logic {ST_IDLE, ST_RUN} cntseq_state_e;

    function automatic logic [CNT_ENT_BW-1:0] cnt_entry(
        input logic [CNT_TIME_BW-1:0] t,
        input logic [CNT_CWD_BW-1:0]  c,
        input logic [CNT_CWD_BW-1:0]  s
    );
        return {t, c, s};
    endfunction

    // RESM entries carry their index in timing/cwdsp so every slot is distinct.
    function automatic logic [CNT_ENT_BW-1:0] default_entry(
        input int unsigned prog,
        input int unsigned idx
    );
        logic [CNT_ENT_BW-1:0] e;
        e = '0;
        case (prog)
            SELCNT_INIT: begin
                case (idx)
                    0: e = cnt_entry(MEAS_CYCLE, CWD_MEAS, CWD_I);
                    1: e = cnt_entry(INIT_CYCLE, CWD_INIT, CWD_I);
                    2: e = cnt_entry(INIT_CYCLE, CWD_IDLE, CWD_HOLD);
                    default: e = '0;
                endcase
            end
            SELCNT_MEAS: begin
                case (idx)
                    0: e = cnt_entry(MEAS_CYCLE, CWD_MEAS, CWD_I);
                    1: e = cnt_entry(MEAS_CYCLE, CWD_MEAS, CWD_HOLD);
                    default: e = '0;
                endcase
            end
            SELCNT_RESM: begin
                if (idx < RESM_LEN)
                    e = cnt_entry(RESM_CYCLE + CNT_TIME_BW'(idx), CWD_RESM, CNT_CWD_BW'(idx));
            end
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/psu_cntseq_store.sv
// NUM_PROG x MAX_LEN entry array: one synchronous write port, one
// combinational read port. Contents are intentionally not reset.
module psu_cntseq_store #(
    parameter int unsigned NUM_PROG = 4,
    parameter int unsigned MAX_LEN  = 32,
    parameter int unsigned ENT_BW   = 18,
    parameter int unsigned PROG_BW  = 2,
    parameter int unsigned ADDR_BW  = 5
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [PROG_BW-1:0] wprog_i,
    input  logic [ADDR_BW-1:0] waddr_i,
    input  logic [ENT_BW-1:0]  wdata_i,
    input  logic [PROG_BW-1:0] rprog_i,
    input  logic [ADDR_BW-1:0] raddr_i,
    output logic [ENT_BW-1:0]  rdata_o
);

    logic [ENT_BW-1:0] mem_q [NUM_PROG][MAX_LEN];

    always_ff @(posedge clk_i) begin
        if (we_i)
            mem_q[wprog_i][waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[rprog_i][raddr_i];

endmodule

// File: rtl/psu_cntseq_prog.sv
// Run-time programmable PSU control-word/timing sequencer: per-program
// lengths, repeat passes, valid/ready output, abort and running-program write lock.
module psu_cntseq_prog
    import psu_cntseq_prog_pkg::*;
#(
    parameter  int unsigned NUM_PROG = CNT_NUM_PROG,
    parameter  int unsigned MAX_LEN  = CNT_MAX_LEN,
    parameter  int unsigned TIME_BW  = CNT_TIME_BW,
    parameter  int unsigned CWD_BW   = CNT_CWD_BW,
    parameter  int unsigned REP_BW   = CNT_REP_BW,
    localparam int unsigned PROG_BW  = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1,
    localparam int unsigned ADDR_BW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int unsigned LEN_BW   = $clog2(MAX_LEN + 1),
    localparam int unsigned ENT_BW   = TIME_BW + 2 * CWD_BW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [PROG_BW-1:0] wr_prog,
    input  logic [ADDR_BW-1:0] wr_addr,
    input  logic [ENT_BW-1:0]  wr_data,
    input  logic               len_wr_en,
    input  logic [PROG_BW-1:0] len_prog,
    input  logic [LEN_BW-1:0]  len_val,
    input  logic [PROG_BW-1:0] sel_prog,
    input  logic [REP_BW-1:0]  rep,
    input  logic               start,
    input  logic               abort,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [TIME_BW-1:0] timing,
    output logic [CWD_BW-1:0]  cwd,
    output logic [CWD_BW-1:0]  cwdsp,
    output logic [LEN_BW-1:0]  id_len,
    output logic [ADDR_BW-1:0] cur_id,
    output logic               busy,
    output logic               done,
    output logic               err
);

    cntseq_state_e      state_q, state_d;
    logic [PROG_BW-1:0] run_prog_q, run_prog_d;
    logic [ADDR_BW-1:0] ptr_q, ptr_d;
    logic [REP_BW-1:0]  pass_q, pass_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [LEN_BW-1:0]  len_q [NUM_PROG];

    logic [LEN_BW-1:0]  sel_len, run_len, len_sat;
    logic               sel_ok, wr_prog_ok, len_prog_ok;
    logic               running, wr_block, len_block, mem_we, len_we, last_entry;
    logic [ENT_BW-1:0]  rd_data;

    // Explicit per-program decode keeps lookups in range for non-power-of-two NUM_PROG.
    always_comb begin
        sel_len     = '0;
        run_len     = '0;
        sel_ok      = 1'b0;
        wr_prog_ok  = 1'b0;
        len_prog_ok = 1'b0;
        for (int unsigned i = 0; i < NUM_PROG; i++) begin
            if (sel_prog == PROG_BW'(i)) begin
                sel_ok  = 1'b1;
                sel_len = len_q[i];
            end
            if (run_prog_q == PROG_BW'(i)) run_len = len_q[i];
            if (wr_prog == PROG_BW'(i))    wr_prog_ok = 1'b1;
            if (len_prog == PROG_BW'(i))   len_prog_ok = 1'b1;
        end
    end

    assign running    = (state_q == ST_RUN);
    assign wr_block   = running && (wr_prog == run_prog_q);
    assign len_block  = running && (len_prog == run_prog_q);
    assign mem_we     = wr_en && wr_prog_ok && !wr_block;
    assign len_we     = len_wr_en && len_prog_ok && !len_block;
    assign len_sat    = (len_val > LEN_BW'(MAX_LEN)) ? LEN_BW'(MAX_LEN) : len_val;
    assign last_entry = (LEN_BW'(ptr_q) + LEN_BW'(1)) >= run_len;

    always_comb begin
        state_d    = state_q;
        run_prog_d = run_prog_q;
        ptr_d      = ptr_q;
        pass_d     = pass_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (!sel_ok || sel_len == '0) begin
                            err_d = 1'b1;
                        end else begin
                            run_prog_d = sel_prog;
                            ptr_d      = '0;
                            pass_d     = (rep == '0) ? REP_BW'(1) : rep;
                            state_d    = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (out_ready) begin
                        if (last_entry) begin
                            ptr_d  = '0;
                            pass_d = pass_q - REP_BW'(1);
                            if (pass_q == REP_BW'(1)) begin
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end else begin
                            ptr_d = ptr_q + ADDR_BW'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if ((wr_en && !mem_we) || (len_wr_en && !len_we))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            run_prog_q <= '0;
            ptr_q      <= '0;
            pass_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_prog_q <= run_prog_d;
            ptr_q      <= ptr_d;
            pass_q     <= pass_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_PROG; i++) len_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_PROG; i++)
                if (len_we && len_prog == PROG_BW'(i)) len_q[i] <= len_sat;
        end
    end

    psu_cntseq_store #(
        .NUM_PROG (NUM_PROG),
        .MAX_LEN  (MAX_LEN),
        .ENT_BW   (ENT_BW),
        .PROG_BW  (PROG_BW),
        .ADDR_BW  (ADDR_BW)
    ) u_store (
        .clk_i   (clk),
        .we_i    (mem_we),
        .wprog_i (wr_prog),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .rprog_i (run_prog_q),
        .raddr_i (ptr_q),
        .rdata_o (rd_data)
    );

    assign out_valid              = running;
    assign {timing, cwd, cwdsp}   = running ? rd_data : '0;
    assign id_len                 = running ? run_len : '0;
    assign cur_id                 = running ? ptr_q : '0;
    assign busy                   = running;
    assign done                   = done_q;
    assign err                    = err_q;

endmodule

// File: doc/psu_cntseq_prog.md
Name: psu_cntseq_prog

Overview:
- Parametrised, run-time-programmable successor to the PSU fixed control-word/timing sequence store.
- Holds NUM_PROG independent circular sequences (INIT/MEAS/RESM and future ones). Each entry is {timing, cwd, cwdsp}.
- Uses a read pointer instead of physical shifting.
- Adds programmable lengths, repeat counts, valid/ready output handshake, abort, and write-protection of the running program.
- Sits between the PSU controller (start/select) and the cwd/timing consumer.

Parameters:
NUM_PROG, 4, number of sequences
MAX_LEN, 32, max entries per sequence
TIME_BW, 8, timing field width
CWD_BW, 5, cwd and cwdsp field width
REP_BW, 8, repeat-count width
(derived) PROG_BW=clog2(NUM_PROG), ADDR_BW=clog2(MAX_LEN), LEN_BW=clog2(MAX_LEN+1), ENT_BW=TIME_BW+2*CWD_BW

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
wr_en  in  1  write one entry
wr_prog  in  PROG_BW  target program
wr_addr  in  ADDR_BW  target entry
wr_data  in  ENT_BW  {timing,cwd,cwdsp}
len_wr_en  in  1  write program length
len_prog  in  PROG_BW  target program
len_val  in  LEN_BW  length, 0..MAX_LEN
sel_prog  in  PROG_BW  program to run, sampled on start
rep  in  REP_BW  passes, sampled on start; 0 treated as 1
start  in  1  launch request
abort  in  1  stop immediately
out_ready  in  1  consumer accepts current entry
out_valid  out  1  entry outputs valid
timing  out  TIME_BW  current entry timing
cwd  out  CWD_BW  current entry cwd
cwdsp  out  CWD_BW  current entry cwdsp
id_len  out  LEN_BW  length of running program
cur_id  out  ADDR_BW  current entry index
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at normal completion
err  out  1  one-cycle pulse on rejected start/write

Behaviour:
- Reset (rst=0, async): state=IDLE; ptr, pass counter, run_prog, and all lengths cleared to 0. Outputs out_valid/busy/done/err=0; timing/cwd/cwdsp/id_len/cur_id=0. Entry storage is not reset; programs must be written before use.
- States: IDLE, RUN.
- IDLE + start:
  - If len[sel_prog]=0 or sel_prog>=NUM_PROG: err pulse next cycle, remain IDLE.
  - Otherwise, next edge: run_prog<=sel_prog, ptr<=0, passes_left<=max(rep,1), RUN.
- RUN:
  - out_valid=1. timing/cwd/cwdsp = mem[run_prog][ptr], combinational from registered ptr.
  - id_len=len[run_prog]; cur_id=ptr.
  - Outputs hold stable while out_valid && !out_ready.
- Accept (out_valid && out_ready):
  - If ptr<id_len-1: ptr+1.
  - At ptr=id_len-1: ptr wraps to 0 and passes_left decrements. If passes_left was 1: done pulse same edge, go to IDLE, out_valid=0 next cycle.
- Throughput: one entry per cycle with out_ready held high. A length-L, rep=R run takes L*R accepting cycles. Start-to-first out_valid latency is 1 cycle.
- abort (any state): next edge → IDLE, ptr=0, no done pulse. abort beats start and an accept in the same cycle.
- start while RUN: ignored, no err.
- Outside RUN, all entry outputs read 0.
- Writes:
  - Permitted to any program except run_prog while RUN. A write to run_prog while RUN (either port) is dropped with an err pulse.
  - Writes to other programs take effect next edge.
  - Simultaneous wr_en and len_wr_en are both honoured.
  - len_val>MAX_LEN saturates to MAX_LEN.
  - A write to wr_prog==sel_prog on the same cycle as start is honoured; the run sees the new data.
- err is a single pulse even if several violations coincide.

Decomposition:
- Shared package: the CNT field layout (TIME_BW, CWD_BW, ENT_BW), CWD_* and *_CYCLE codes, SELCNT_* program indices, and the default INIT/MEAS/RESM sequences used by loader/testbench.
- One sub-module, psu_cntseq_store: NUM_PROG×MAX_LEN entry array with one write port and one combinational read port.
- Controller FSM, length registers and counters stay in the top level.

Test Plan:
- Load INIT default (3 entries, first {MEAS_CYCLE,CWD_MEAS,CWD_I}); start sel=INIT rep=1; out_ready=1 → out_valid cycles 1-3, cur_id 0,1,2, done pulse at third accept, busy=0 after.
- RESM 20 entries, rep=2, out_ready toggling 1/0 → each entry held while ready=0; 40 accepts; cur_id wraps 19→0 once; single done.
- start with len=0, or sel_prog=NUM_PROG → err pulse, busy stays 0.
- RUN MEAS (len 2); wr_en to MEAS → err, entry unchanged. wr_en to INIT in the same run → written, verified on a later run.
- abort asserted on the same cycle as the last accept → IDLE, no done. Next start runs from entry 0.
- Drop rst mid-run, asynchronously between edges → outputs 0 immediately; lengths 0; a start after release gives err.
